// File: rtl/noc_vc_mux_rr_if.sv
// Per-VC handshake bundle between the core, the VC multiplexer and the router LOCAL input.
//
// Handshake rule, identical on both sides: a flit moves on a clock edge where valid and
// ready of the same VC are both high. Valid must never depend on ready. Ready may depend
// on valid. On the core side (in_*) the multiplexer drives ready. On the router side
// (out_*) the multiplexer drives a one-hot valid and the router drives ready.
interface noc_vc_mux_rr_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int CHANNELS   = 2
);
  logic [CHANNELS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [CHANNELS-1:0]                 in_last;
  logic [CHANNELS-1:0]                 in_valid;
  logic [CHANNELS-1:0]                 in_ready;
  logic [FLIT_WIDTH-1:0]               out_flit;
  logic                                out_last;
  logic [CHANNELS-1:0]                 out_valid;
  logic [CHANNELS-1:0]                 out_ready;

  // Multiplexer view.
  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid
  );

  // Core/router (environment) view.
  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid
  );
endinterface

// File: rtl/noc_vc_mux_rr.sv
// Round-robin virtual-channel multiplexer with optional packet lock and a single
// registered output stage. The output register can drain and reload in the same cycle,
// which gives one flit per cycle with no bubbles.
module noc_vc_mux_rr #(
  parameter int FLIT_WIDTH  = 32,
  parameter int CHANNELS    = 2,
  parameter bit LOCK_PACKET = 1'b1,
  localparam int PTR_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  noc_vc_mux_rr_if.slave   vc,
  output logic             busy,
  output logic [PTR_W-1:0] dbg_ptr_o,
  output logic             dbg_lock_o,
  output logic [PTR_W-1:0] dbg_lock_ch_o
);

  typedef enum logic {
    ST_OPEN   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e           state_q, state_d;
  logic [PTR_W-1:0]      lock_ch_q, lock_ch_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  reg_valid_q, reg_valid_d;
  logic [PTR_W-1:0]      reg_ch_q, reg_ch_d;
  logic [FLIT_WIDTH-1:0] flit_q, flit_d;
  logic                  last_q, last_d;

  logic                  drain;
  logic                  load_en;
  logic                  accept;
  logic [CHANNELS-1:0]   elig;
  logic [CHANNELS-1:0]   grant;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      scan_idx;
  logic                  found;

  // Eligibility, rotating-priority grant and ready generation.
  always_comb begin
    drain     = reg_valid_q & vc.out_ready[reg_ch_q];
    load_en   = ~reg_valid_q | drain;
    elig      = vc.in_valid;
    if (state_q == ST_LOCKED) begin
      elig = vc.in_valid & (CHANNELS'(1) << lock_ch_q);
    end
    grant     = '0;
    grant_idx = '0;
    scan_idx  = '0;
    found     = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      scan_idx = PTR_W'((int'(ptr_q) + i) % CHANNELS);
      if (!found && elig[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
    // No ready is raised while reset is asserted.
    accept      = found & load_en & ~rst;
    vc.in_ready = accept ? grant : '0;
  end

  // Next-state logic: output register, lock state and round-robin pointer.
  always_comb begin
    state_d     = state_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    reg_valid_d = reg_valid_q;
    reg_ch_d    = reg_ch_q;
    flit_d      = flit_q;
    last_d      = last_q;
    if (accept) begin
      reg_valid_d = 1'b1;
      reg_ch_d    = grant_idx;
      flit_d      = vc.in_flit[grant_idx];
      last_d      = vc.in_last[grant_idx];
      if (LOCK_PACKET && !vc.in_last[grant_idx]) begin
        // Mid-packet: pin the grant to this VC, priority does not rotate yet.
        state_d   = ST_LOCKED;
        lock_ch_d = grant_idx;
      end else begin
        state_d = ST_OPEN;
        ptr_d   = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + 1'b1;
      end
    end else if (drain) begin
      // Payload keeps its stale value; only valid drops.
      reg_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OPEN;
      lock_ch_q   <= '0;
      ptr_q       <= '0;
      reg_valid_q <= 1'b0;
      reg_ch_q    <= '0;
      flit_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
      reg_valid_q <= reg_valid_d;
      reg_ch_q    <= reg_ch_d;
      flit_q      <= flit_d;
      last_q      <= last_d;
    end
  end

  assign vc.out_flit    = flit_q;
  assign vc.out_last    = last_q;
  assign vc.out_valid   = reg_valid_q ? (CHANNELS'(1) << reg_ch_q) : '0;
  assign busy           = reg_valid_q | (state_q == ST_LOCKED);
  assign dbg_ptr_o      = ptr_q;
  assign dbg_lock_o     = (state_q == ST_LOCKED);
  assign dbg_lock_ch_o  = lock_ch_q;

endmodule

// File: doc/noc_vc_mux_rr.md
# noc_vc_mux_rr

Parametrised virtual-channel multiplexer for the local injection port of each mesh node. It merges CHANNELS independent valid/ready flit streams from the compute core onto the single physical router channel. Arbitration is round-robin and, in packet mode, a grant is held from the first flit of a packet until its last flit. The selected flit is registered, and valid is presented one-hot on the owning VC. The block sits between the core's per-VC outputs and the router LOCAL input, replacing plain per-node wiring and generalising to any VC count.

## Interface
- FLIT_WIDTH, 32, flit payload width.
- CHANNELS, 2, number of virtual channels (≥1).
- LOCK_PACKET, 1, mode select.
  - 1: the grant is held until a flit with last=1 is accepted.
  - 0: re-arbitration happens on every flit.
- clk  in  1  clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- in_flit  in  [CHANNELS][FLIT_WIDTH]  per-VC flit from the core.
- in_last  in  [CHANNELS]  per-VC last-flit marker.
- in_valid  in  [CHANNELS]  per-VC valid.
- in_ready  out  [CHANNELS]  per-VC ready; at most one bit is high per cycle.
- out_flit  out  FLIT_WIDTH  registered flit to the router LOCAL input.
- out_last  out  1  registered last marker.
- out_valid  out  [CHANNELS]  one-hot valid on the owning VC; all-zero when empty.
- out_ready  in  [CHANNELS]  per-VC ready from the router.
- busy  out  1  high while the output register is full or a packet lock is held.

## Operation
- State:
  - Output register: reg_valid, reg_ch, out_flit, out_last.
  - Round-robin pointer ptr, width max(1, clog2(CHANNELS)).
  - Lock flag lock_v and lock channel lock_ch.
- drain = reg_valid & out_ready[reg_ch].
- load_en = !reg_valid | drain. The register accepts a new flit in the same cycle the old one drains.
- Eligible set:
  - lock_v=1: only lock_ch, and only if in_valid[lock_ch] is high. Other VCs are not granted even if valid.
  - lock_v=0: all VCs with in_valid high.
- Grant: the first eligible VC scanning ptr, ptr+1, … modulo CHANNELS. It is one-hot or zero.
- in_ready[c] = load_en & grant[c]. in_ready may depend on in_valid (combinational grant). in_valid must not depend on in_ready.
- Accept of channel c = in_valid[c] & in_ready[c]. On accept:
  - Register loads in_flit[c] and in_last[c]; reg_ch=c; reg_valid=1.
  - LOCK_PACKET=1, last=0: lock_v=1, lock_ch=c; ptr unchanged.
  - LOCK_PACKET=1, last=1: lock_v=0; ptr=(c+1) mod CHANNELS.
  - LOCK_PACKET=0: ptr=(c+1) mod CHANNELS; lock never sets.
- Drain without accept: reg_valid=0; out_flit and out_last hold their stale value.
- out_valid = reg_valid ? onehot(reg_ch) : 0.
- CHANNELS=1: ptr stays 0; the block degenerates to a one-stage pipeline register with packet tracking.
- busy = reg_valid | lock_v.

## Timing
- Synchronous reset (rst=1 at a clk edge), including mid-packet:
  - reg_valid=0, out_valid=0, out_flit=0, out_last=0.
  - ptr=0, lock_v=0, lock_ch=0, busy=0.
  - in_ready is 0 during the reset cycle.
- Latency: flit accepted at edge N appears with out_valid at N+1.
- Throughput: 1 flit/cycle sustained while the router holds out_ready[reg_ch]=1.
- Backpressure: if out_ready[reg_ch]=0, the register holds its contents, all in_ready are 0, and no state changes.
- out_ready bits of VCs other than reg_ch are ignored.
- Simultaneous drain and accept in one cycle: reg_valid stays 1 and the new flit replaces the old. No bubble.
- Wrap-around: ptr=CHANNELS-1 followed by a grant advances ptr to 0.
- Single-flit packet (last=1 on the first flit) never sets the lock.
- A locked VC with in_valid low leaves the grant idle and the lock held; other VCs starve until the last flit is accepted.

## Test plan
- Reset mid-packet:
  - Stimulus: lock held on VC1, rst=1 for one cycle.
  - Response: all outputs 0 and busy=0 next cycle. A VC0 flit 0xA5 then wins and appears on out_valid=2'b01 one cycle later.
- Round-robin fairness:
  - Stimulus: CHANNELS=4, LOCK_PACKET=0, all VCs continuously valid with single-flit packets, out_ready all 1.
  - Response: grant order 0,1,2,3,0,… with one flit per cycle and no bubbles.
- Packet lock:
  - Stimulus: VC0 sends a 3-flit packet (0x10, 0x11, 0x12 with last on the third); VC1 is valid throughout.
  - Response: out shows 0x10, 0x11, 0x12 on VC0 consecutively, then VC1's flit. in_ready[1]=0 for the three cycles.
- Backpressure:
  - Stimulus: out_ready[reg_ch]=0 for 3 cycles with a flit registered.
  - Response: out_flit stable, in_ready all 0, ptr unchanged. Flow resumes on release with no flit lost or duplicated.
- Locked VC idles:
  - Stimulus: VC0 sends flit 1 (last=0), drops in_valid for 2 cycles while VC1 is valid, then sends last.
  - Response: VC1 is not granted until the cycle after VC0's last flit is accepted.
- Wrong-VC ready:
  - Stimulus: reg_ch=1 with out_ready=2'b01.
  - Response: the register does not drain and out_valid stays 2'b10.
